// File: rtl/reg_share_arb.sv
// reg_share_arb
//   Round-robin write arbiter for one shared WIDTH-bit register. Each cycle at
//   most one requester is granted; its data lands in the register on the next
//   rising edge, and the arbiter remembers which requester wrote last.
//
// Optional feature macro: REG_ARB_LOCK_EN
//   When defined, a lock port lets a granted requester keep exclusive access
//   to the register for consecutive writes until it drops req or lock.
//
// Ports
//   clk      in   1        clock, all state changes on posedge
//   reset    in   1        synchronous, active-high reset
//   req      in   N        per-requester write request (level)
//   wdata    in   N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
//   lock     in   N        per-requester lock request (REG_ARB_LOCK_EN only)
//   gnt      out  N        one-hot grant or zero, combinational
//   q        out  WIDTH    shared register contents
//   q_valid  out  1        register written at least once since reset
//   owner    out  IW       index of the requester that performed the last write
module reg_share_arb #(
  parameter int  N     = 4,
  parameter int  WIDTH = 4,
  localparam int IW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [N-1:0]       lock,
`endif
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic [IW-1:0]      owner
);

  // Data array is padded to a power of two so any IW-bit index is in range.
  localparam int NP2 = 1 << IW;

  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic [IW-1:0]    r_owner;
`ifdef REG_ARB_LOCK_EN
  logic             r_locked;
  logic [IW-1:0]    r_lock_id;
`endif

  logic             w_found;
  logic [IW-1:0]    w_gidx;
  logic [IW-1:0]    w_ptr_inc;
  logic [WIDTH-1:0] w_wdata_arr [NP2];

  generate
    for (genvar gi = 0; gi < NP2; gi++) begin : g_unpack
      if (gi < N) begin : g_real
        assign w_wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_wdata_arr[gi] = '0;
      end
    end
  endgenerate

  // Search ptr, ptr+1, ... wrapping at N (not at 2**IW), first hit wins.
  always_comb begin
    logic [IW:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!w_found && req[idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = idx[IW-1:0];
      end
    end
`ifdef REG_ARB_LOCK_EN
    // A held lock overrides the rotation entirely.
    if (r_locked) begin
      w_found = req[r_lock_id];
      w_gidx  = r_lock_id;
    end
`endif
    if (reset) begin
      w_found = 1'b0;
    end
  end

  assign w_ptr_inc = (w_gidx == IW'(N-1)) ? '0 : w_gidx + IW'(1);
  assign gnt       = w_found ? (N'(1) << w_gidx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
`ifdef REG_ARB_LOCK_EN
      r_locked  <= 1'b0;
      r_lock_id <= '0;
`endif
    end else begin
      if (w_found) begin
        r_q       <= w_wdata_arr[w_gidx];
        r_owner   <= w_gidx;
        r_q_valid <= 1'b1;
`ifdef REG_ARB_LOCK_EN
        if (r_locked) begin
          // Pointer stays frozen while locked; a lock-drop write releases
          // and moves priority past the lock holder.
          if (!lock[r_lock_id]) begin
            r_locked <= 1'b0;
            r_ptr    <= w_ptr_inc;
          end
        end else begin
          r_ptr <= w_ptr_inc;
          if (lock[w_gidx]) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_gidx;
          end
        end
`else
        r_ptr <= w_ptr_inc;
`endif
      end
`ifdef REG_ARB_LOCK_EN
      // Lock holder withdrew its request: release without a write.
      if (r_locked && !req[r_lock_id]) begin
        r_locked <= 1'b0;
      end
`endif
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign owner   = r_owner;

endmodule
